// File: rtl/up3_mem_arbiter.sv
// rtl/up3_mem_arbiter.sv - CPU/host arbiter for the shared 256x16 uP3 RAM (UP3_ARB_RR_EN selects round-robin ties)
module up3_mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_gnt,
    output logic          o_cpu_rvalid,
    output logic [DW-1:0] o_cpu_rdata,
    input  logic          i_host_req,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_wdata,
    output logic          o_host_gnt,
    output logic          o_host_rvalid,
    output logic [DW-1:0] o_host_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_we,
    input  logic [DW-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_owner;
    logic          w_owner_nxt;
    logic [AW-1:0] r_mem_addr;
    logic [AW-1:0] w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] w_mem_wdata_nxt;
    logic          r_mem_we;
    logic          w_mem_we_nxt;
    logic          w_pick_host;

`ifdef UP3_ARB_RR_EN
    logic          r_last;
    logic          w_last_nxt;

    // Ties go to whichever port did not win last time
    assign w_pick_host = i_host_req && (!i_cpu_req || (r_last == OWN_CPU));
`else
    // Fixed priority: the host only wins when the CPU is not asking
    assign w_pick_host = i_host_req && !i_cpu_req;
`endif

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and next values for the RAM-side command registers
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_we_nxt    = 1'b0;
`ifdef UP3_ARB_RR_EN
        w_last_nxt      = r_last;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_cpu_req || i_host_req) begin
                    w_state_nxt     = S_ACCESS;
                    w_owner_nxt     = w_pick_host ? OWN_HOST : OWN_CPU;
                    w_mem_addr_nxt  = w_pick_host ? i_host_addr  : i_cpu_addr;
                    w_mem_wdata_nxt = w_pick_host ? i_host_wdata : i_cpu_wdata;
                    w_mem_we_nxt    = w_pick_host ? i_host_we    : i_cpu_we;
`ifdef UP3_ARB_RR_EN
                    w_last_nxt      = w_pick_host ? OWN_HOST : OWN_CPU;
`endif
                end
            end
            S_ACCESS: begin
                // Writes complete at the edge ending ACCESS; reads need a RESP cycle
                w_state_nxt = r_mem_we ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Owner, tie-break history and registered RAM command
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner     <= OWN_CPU;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
`ifdef UP3_ARB_RR_EN
            r_last      <= OWN_HOST;
`endif
        end else begin
            r_owner     <= w_owner_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_we    <= w_mem_we_nxt;
`ifdef UP3_ARB_RR_EN
            r_last      <= w_last_nxt;
`endif
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_we    = r_mem_we;

    // Responses decode straight from registered state so reset kills them immediately
    assign o_cpu_gnt     = (r_state == S_ACCESS) && (r_owner == OWN_CPU);
    assign o_host_gnt    = (r_state == S_ACCESS) && (r_owner == OWN_HOST);
    assign o_cpu_rvalid  = (r_state == S_RESP)   && (r_owner == OWN_CPU);
    assign o_host_rvalid = (r_state == S_RESP)   && (r_owner == OWN_HOST);
    assign o_cpu_rdata   = o_cpu_rvalid  ? i_mem_rdata : '0;
    assign o_host_rdata  = o_host_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_up3_mem_arbiter.sv
// tb/tb_up3_mem_arbiter.sv - directed self-checking bench for up3_mem_arbiter
module tb_up3_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, host_req, host_we;
    logic [7:0]  cpu_addr, host_addr;
    logic [15:0] cpu_wdata, host_wdata;
    logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [15:0] cpu_rdata, host_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    logic [15:0] ram [0:255];
    logic [15:0] ram_q;

    int checks = 0;
    int errors = 0;

`ifdef UP3_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    up3_mem_arbiter #(.AW(8), .DW(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_gnt    (cpu_gnt),
        .o_cpu_rvalid (cpu_rvalid),
        .o_cpu_rdata  (cpu_rdata),
        .i_host_req   (host_req),
        .i_host_we    (host_we),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_host_gnt   (host_gnt),
        .o_host_rvalid(host_rvalid),
        .o_host_rdata (host_rdata),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_we     (mem_we),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM: address sampled at the edge, q valid the following cycle
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_q <= ram[mem_addr];
    end
    assign mem_rdata = ram_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " gnt"},    {30'd0, cpu_gnt, host_gnt}, 32'd0);
        check({tag, " rvalid"}, {30'd0, cpu_rvalid, host_rvalid}, 32'd0);
        check({tag, " rdata"},  {cpu_rdata, host_rdata}, 32'd0);
    endtask

    initial begin
        int    cpu_gnts;
        int    host_gnts;
        bit    seen_we;
        bit    exp_cg, exp_hg, exp_cv, exp_hv;

        for (int i = 0; i < 256; i++) ram[i] = 16'h0100 + 16'(i);
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;

        // Reset state
        step(); step();
        check_quiet("reset");
        check("reset mem", {mem_we, 7'd0, mem_addr, mem_wdata}, 32'd0);
        rst_n = 1'b1;

        // Twenty idle cycles: no write strobe, no responses
        seen_we = 1'b0;
        cpu_gnts = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (mem_we) seen_we = 1'b1;
            if (cpu_gnt || host_gnt || cpu_rvalid || host_rvalid) cpu_gnts++;
        end
        check("idle mem_we", {31'd0, seen_we}, 32'd0);
        check("idle activity", cpu_gnts, 0);

        // CPU write 0x10 <= 0xBEEF, req dropped in the gnt cycle
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
        step();
        check("cpu wr gnt", {31'd0, cpu_gnt}, 32'd1);
        check("cpu wr bus", {mem_we, 7'd0, mem_addr, mem_wdata}, {1'b1, 7'd0, 8'h10, 16'hBEEF});
        cpu_req = 0;
        step();
        check("cpu wr we one cycle", {30'd0, mem_we, cpu_gnt}, 32'd0);

        // CPU read 0x10
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        step();
        check("cpu rd gnt", {30'd0, cpu_gnt, mem_we}, 32'd2);
        check("cpu rd early rvalid", {31'd0, cpu_rvalid}, 32'd0);
        cpu_req = 0;
        step();
        check("cpu rd rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("cpu rd data", cpu_rdata, 32'h0000BEEF);
        step();
        check_quiet("after cpu rd");

        // Host write 0xFF <= 0x1234, then CPU read 0xFF
        host_req = 1; host_we = 1; host_addr = 8'hFF; host_wdata = 16'h1234;
        step();
        check("host wr gnt", {30'd0, host_gnt, cpu_gnt}, 32'd2);
        check("host wr bus", {mem_we, 7'd0, mem_addr, mem_wdata}, {1'b1, 7'd0, 8'hFF, 16'h1234});
        host_req = 0;
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'hFF;
        step();
        check("cpu rd FF gnt", {31'd0, cpu_gnt}, 32'd1);
        cpu_req = 0;
        step();
        check("cpu rd FF data", {cpu_rvalid, 15'd0, cpu_rdata}, {1'b1, 15'd0, 16'h1234});
        check("host quiet in cpu resp", {host_rvalid, 15'd0, host_rdata}, 32'd0);
        step();

        // Fresh reset so the round-robin history starts from HOST
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Both ports read continuously
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
        host_req = 1; host_we = 0; host_addr = 8'h02;
        host_gnts = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_cg = (k % 3 == 1) && (!RR || (k % 6 == 1));
            exp_hg = RR && (k % 6 == 4);
            exp_cv = (k % 3 == 2) && (!RR || (k % 6 == 2));
            exp_hv = RR && (k % 6 == 5);
            check($sformatf("sat gnt k=%0d", k), {30'd0, cpu_gnt, host_gnt}, {30'd0, exp_cg, exp_hg});
            check($sformatf("sat rvalid k=%0d", k), {30'd0, cpu_rvalid, host_rvalid}, {30'd0, exp_cv, exp_hv});
            if (exp_cv) check($sformatf("sat cpu data k=%0d", k), cpu_rdata, 32'h0101);
            if (exp_hv) check($sformatf("sat host data k=%0d", k), host_rdata, 32'h0102);
            if (host_gnt) host_gnts++;
        end
        check("sat host gnt count", host_gnts, RR ? 2 : 0);
        cpu_req = 0; host_req = 0;
        step(); step(); step();

        // Reset in the middle of a host write ACCESS to 0x20
        host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 16'hAAAA;
        step();
        check("rst host gnt", {30'd0, host_gnt, mem_we}, 32'd3);
        #2;
        rst_n = 1'b0;
        host_req = 0;
        #1;
        check("rst we drop", {31'd0, mem_we}, 32'd0);
        check_quiet("rst mid access");
        step(); step();
        rst_n = 1'b1;
        host_gnts = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (host_gnt || host_rvalid) host_gnts++;
        end
        check("no host gnt after rst", host_gnts, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
        step();
        cpu_req = 0;
        step();
        check("rd 0x20 known", {31'd0, $isunknown(cpu_rdata)}, 32'd0);
        check("rd 0x20 data", {cpu_rvalid, 15'd0, cpu_rdata}, {1'b1, 15'd0, 16'h0120});
        step();

        // Requester drops req in its gnt cycle: exactly one grant
        host_req = 1; host_we = 0; host_addr = 8'h33;
        cpu_gnts = 0; host_gnts = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (host_gnt) begin
                host_gnts++;
                host_req = 0;
            end
            if (cpu_gnt) cpu_gnts++;
        end
        check("single gnt count", host_gnts, 1);
        check("single cpu gnt", cpu_gnts, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/up3_mem_arbiter.md
# up3_mem_arbiter

Two-port arbiter that shares the uP3 processor's single-port 256x16 synchronous program/data RAM between the CPU core and a host loader/debug port. Each requester presents one read or write at a time through a req/gnt handshake. The arbiter drives the RAM's address, write-data and write-enable from registers and returns read data with a fixed latency. It sits between the CPU's memory interface, the host port and the RAM instance.

## Interface
- AW, 8, RAM address width (256 words)
- DW, 16, RAM data width
- clk  in  1  system clock; RAM clocked on the same edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held with cmd fields until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  word address
- cpu_wdata  in  DW  write data
- cpu_gnt  out  1  one-cycle pulse: CPU command accepted and on RAM bus
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DW  read data (mem_rdata pass-through, gated to 0 when not valid)
- host_req / host_we / host_addr / host_wdata  in  1/1/AW/DW  host command, same rules as CPU
- host_gnt / host_rvalid / host_rdata  out  1/1/DW  host responses, same rules as CPU
- mem_addr  out  AW  RAM address (registered)
- mem_wdata  out  DW  RAM write data (registered)
- mem_we  out  1  RAM write enable (registered; high only in ACCESS of a write)
- mem_rdata  in  DW  RAM read output (unregistered q, valid the cycle after address edge)

## Operation
- States: IDLE, ACCESS, RESP. State register `owner` ∈ {CPU, HOST}, and register `last` (previous winner).
- IDLE: at clock edge, if any req is high, choose the winner, load mem_addr/mem_wdata/mem_we from the winner's fields, set owner, go to ACCESS. If no req is high, remain in IDLE with mem_we=0; mem_addr holds its value.
- Arbitration: a single requester always wins. If both are requesting, the winner is the requester that is not `last`. `last` is updated on every grant.
- ACCESS: the owner's gnt is high for this cycle only. The RAM samples mem_* at the edge that ends ACCESS. After a write, go to IDLE with mem_we cleared. After a read, go to RESP with mem_we=0.
- RESP: the owner's rvalid is high and its rdata = mem_rdata. The non-owner's rdata = 0. Go to IDLE.
- Requester rule: the requester must hold its command stable until it sees gnt. In the cycle gnt is high, it drives its next command, or deasserts req, for the next edge. req is not sampled in ACCESS or RESP.
- The losing requester keeps req high and is served on the next IDLE sample. It is never dropped.
- No address range checks. All addresses from 0 to 2^AW-1 are passed through unchanged.

## Timing
- Reset: state=IDLE, last=HOST (CPU wins the first tie), owner=CPU, mem_addr=0, mem_wdata=0, mem_we=0. All gnt, rvalid and rdata outputs are 0.
- Write: req is sampled at edge E0. gnt and mem_we are high during E0→E1. The RAM is written at E1. Occupancy is 2 cycles including IDLE.
- Read: req is sampled at E0. gnt is high during E0→E1. rvalid and rdata are valid during E1→E2. Occupancy is 3 cycles. Read latency is 1 cycle after gnt.
- With both ports saturated, the ports alternate strictly: CPU, HOST, CPU, …
- Reset asserted mid-ACCESS: mem_we drops to 0 asynchronously and the write may be lost. No gnt or rvalid is emitted after reset.
- Reset asserted mid-RESP: rvalid drops immediately and the transaction is abandoned. The requester must reissue.
- gnt and rvalid are never high for both ports in the same cycle. At most one transaction is in flight at a time.

## Configuration
- UP3_ARB_RR_EN defined: round-robin tie-break as above.
- UP3_ARB_RR_EN undefined: fixed priority, CPU always wins ties.
  - `last` is removed.
  - The host can starve while the CPU requests every IDLE cycle.
  - All other timing is identical.

## Test plan
- Reset then idle: all outputs 0, mem_we never high over 20 cycles with no requests.
- CPU write addr 0x10 data 0xBEEF, then CPU read 0x10:
  - write gnt 1 cycle after req.
  - mem_we high exactly 1 cycle.
  - read rvalid 1 cycle after gnt with cpu_rdata=0xBEEF.
- Host write addr 0xFF data 0x1234, then CPU read 0xFF: cpu_rdata=0x1234, host_rvalid stays 0.
- Both ports read continuously (CPU addr 0x01, host addr 0x02):
  - with UP3_ARB_RR_EN, grants alternate CPU/HOST starting with CPU, each gnt 3 cycles apart.
  - without UP3_ARB_RR_EN, host_gnt never asserts.
- rst_n pulsed low during ACCESS of a host write to 0x20 (data 0xAAAA): mem_we falls at once, state IDLE, no host_gnt repeat. A later read of 0x20 does not return a partial or X value.
- Requester drops req in its gnt cycle: exactly one access is issued, no duplicate gnt.
